// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter: merges in-order WB results with buffered long-latency
// results onto the single register-file write port.   Rev 1.0
// ============================================================================
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pipe_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]     pipe_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]         pipe_data_i,
  input  logic                          lu_valid_i,
  output logic                          lu_ready_o,
  input  logic [REG_ADDR_WIDTH-1:0]     lu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]         lu_data_i,
  output logic [REG_ADDR_WIDTH-1:0]     wr_addr_o,
  output logic [DATA_WIDTH-1:0]         wr_data_o,
  output logic                          WB_RegWrite_o,
  output logic [NUM_REGS-1:0]           pending_mask_o,
  output logic                          wb_stall_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_LIMIT - 1);

  logic [REG_ADDR_WIDTH-1:0] slot_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     slot_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]     slot_valid;
  logic [PW-1:0]             head;
  logic [PW-1:0]             tail;
  logic [CW-1:0]             count;
  logic [AW-1:0]             age;
  logic                      wb_stall;

  logic empty;
  logic pipe_live;
  logic pop;
  logic push;

  assign lu_ready_o   = !rst && (count < DEPTH_C);
  assign empty        = (count == '0);
  assign pipe_live    = pipe_valid_i && (pipe_rd_addr_i != '0);
  // A forced-priority cycle pops the head even if the pipe (wrongly) presents a result.
  assign pop          = !empty && (wb_stall || !pipe_live);
  assign push         = lu_valid_i && lu_ready_o && (lu_rd_addr_i != '0);
  assign wb_stall_o   = wb_stall;
  assign fifo_count_o = count;

  always_ff @(posedge clk) begin
    if (push) begin
      slot_addr[tail] <= lu_rd_addr_i;
      slot_data[tail] <= lu_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      slot_valid    <= '0;
      age           <= '0;
      wb_stall      <= 1'b0;
      wr_addr_o     <= '0;
      wr_data_o     <= '0;
      WB_RegWrite_o <= 1'b0;
    end else begin
      // Push needs not-full and pop needs non-empty, so head and tail slots differ here.
      if (push) begin
        tail             <= tail + 1'b1;
        slot_valid[tail] <= 1'b1;
      end
      if (pop) begin
        head             <= head + 1'b1;
        slot_valid[head] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (empty || pop)
        age <= '0;
      else if (age != AGE_MAX)
        age <= age + 1'b1;
      wb_stall <= !empty && !pop && (age == AGE_MAX);

      if (pop) begin
        wr_addr_o     <= slot_addr[head];
        wr_data_o     <= slot_data[head];
        WB_RegWrite_o <= 1'b1;
      end else if (pipe_live) begin
        wr_addr_o     <= pipe_rd_addr_i;
        wr_data_o     <= pipe_data_i;
        WB_RegWrite_o <= 1'b1;
      end else begin
        WB_RegWrite_o <= 1'b0;
      end
    end
  end

  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (slot_valid[i])
        pending_mask_o[slot_addr[i]] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter: directed bench with a cycle model and write scoreboard.
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int LIM   = 8;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_valid = 1'b0;
  logic [4:0]  pipe_addr  = '0;
  logic [31:0] pipe_data  = '0;
  logic        lu_valid   = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_addr    = '0;
  logic [31:0] lu_data    = '0;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [31:0] mask;
  logic        stall;
  logic [2:0]  count;

  regfile_wb_arbiter #(
    .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_REGS(32),
    .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .pipe_valid_i(pipe_valid), .pipe_rd_addr_i(pipe_addr), .pipe_data_i(pipe_data),
    .lu_valid_i(lu_valid), .lu_ready_o(lu_ready), .lu_rd_addr_i(lu_addr), .lu_data_i(lu_data),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data), .WB_RegWrite_o(wr_en),
    .pending_mask_o(mask), .wb_stall_o(stall), .fifo_count_o(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;

  wr_t exp_q[$];
  wr_t mq[$];
  int  m_age   = 0;
  bit  m_stall = 1'b0;
  int  n_cmp   = 0;
  int  n_err   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (mq[i]) m[mq[i].a] = 1'b1;
    return m;
  endfunction

  // One clock cycle: drive, advance the model, then score the registered write.
  task automatic step(input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                      input bit lv, input logic [4:0] la, input logic [31:0] ld);
    bit  m_ready, pl, mpop, nonempty, next_stall;
    wr_t w;
    chk("stall", 64'(stall), 64'(m_stall));
    if (m_stall) pv = 1'b0;
    pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
    lu_valid   = lv; lu_addr   = la; lu_data   = ld;
    m_ready  = (mq.size() < DEPTH);
    nonempty = (mq.size() > 0);
    chk("lu_ready", 64'(lu_ready), 64'(m_ready));
    chk("count", 64'(count), 64'(mq.size()));
    pl   = pv && (pa != 0);
    mpop = nonempty && (m_stall || !pl);
    if (mpop) exp_q.push_back(mq.pop_front());
    else if (pl) begin w.a = pa; w.d = pd; exp_q.push_back(w); end
    if (lv && m_ready && la != 0) begin w.a = la; w.d = ld; mq.push_back(w); end
    next_stall = nonempty && !mpop && (m_age == LIM - 1);
    if (!nonempty || mpop) m_age = 0;
    else if (m_age < LIM - 1) m_age++;
    m_stall = next_stall;
    @(posedge clk);
    @(negedge clk);
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_write", 64'(1), 64'(0));
      else begin
        w = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(w.a));
        chk("wr_data", 64'(wr_data), 64'(w.d));
      end
    end else begin
      chk("missing_write", 64'(exp_q.size()), 64'(0));
    end
    chk("mask", 64'(mask), 64'(model_mask()));
  endtask

  task automatic idle();
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset values while held
    @(negedge clk); @(negedge clk);
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_wr_data", 64'(wr_data), 64'(0));
    chk("rst_ready", 64'(lu_ready), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_mask", 64'(mask), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Pipe only
    step(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
    chk("pipe_x5_en", 64'(wr_en), 64'(1));
    step(1, 5'd0, 32'h1234_5678, 0, 5'd0, 32'd0);
    chk("pipe_x0_en", 64'(wr_en), 64'(0));
    chk("pipe_x0_hold", 64'(wr_addr), 64'(5));

    // Fill the FIFO behind a busy pipe, then drain in order
    for (int i = 1; i <= 4; i++)
      step(1, 5'(10 + i), 32'hA000 + i, 1, 5'(i), 32'(i * 'h11));
    chk("full_count", 64'(count), 64'(4));
    chk("full_ready", 64'(lu_ready), 64'(0));
    chk("full_mask", 64'(mask), 64'h1E);
    step(0, 5'd0, 32'd0, 1, 5'd6, 32'h66);
    for (int i = 0; i < 4; i++) idle();

    // Simultaneous push/pop and x0 long-latency result
    step(1, 5'd12, 32'hC12, 1, 5'd20, 32'h20);
    step(1, 5'd13, 32'hC13, 1, 5'd21, 32'h21);
    chk("sim_count2", 64'(count), 64'(2));
    step(0, 5'd0, 32'd0, 1, 5'd7, 32'h77);
    chk("sim_count_hold", 64'(count), 64'(2));
    step(1, 5'd14, 32'hC14, 1, 5'd0, 32'h99);
    chk("x0_count", 64'(count), 64'(2));
    for (int i = 0; i < 3; i++) idle();

    // Starvation
    step(1, 5'd3, 32'h3000, 1, 5'd9, 32'h99);
    k = 0;
    while (k < 20 && stall !== 1'b1) begin
      step(1, 5'(1 + (k % 8)), $urandom, 0, 5'd0, 32'd0);
      k++;
    end
    chk("starve_delay", 64'(k), 64'(LIM));
    step(1, 5'd4, 32'h4444, 0, 5'd0, 32'd0);
    chk("starve_write_x9", 64'(wr_addr), 64'(9));
    for (int i = 0; i < 3; i++) step(1, 5'd4, $urandom, 0, 5'd0, 32'd0);
    chk("age_cleared_nostall", 64'(stall), 64'(0));

    // Back-to-back mix
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0)
        step(1, 5'($urandom_range(10, 15)), $urandom, 0, 5'd0, 32'd0);
      else
        step(0, 5'd0, 32'd0, 1, 5'($urandom_range(0, 9)), $urandom);
    end
    for (int i = 0; i < 6; i++) idle();
    chk("mix_drained", 64'(mq.size() + exp_q.size()), 64'(0));

    // Reset mid-stream with 3 entries buffered
    for (int i = 1; i <= 3; i++)
      step(1, 5'(20 + i), $urandom, 1, 5'(i), $urandom);
    chk("pre_rst_count", 64'(count), 64'(3));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", 64'(wr_en), 64'(0));
    chk("mid_rst_addr", 64'(wr_addr), 64'(0));
    chk("mid_rst_data", 64'(wr_data), 64'(0));
    chk("mid_rst_ready", 64'(lu_ready), 64'(0));
    chk("mid_rst_count", 64'(count), 64'(0));
    chk("mid_rst_mask", 64'(mask), 64'(0));
    chk("mid_rst_stall", 64'(stall), 64'(0));
    mq.delete(); exp_q.delete(); m_age = 0; m_stall = 1'b0;
    pipe_valid = 1'b0; lu_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_ready", 64'(lu_ready), 64'(1));
    chk("post_rst_en", 64'(wr_en), 64'(0));
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter feeding the register file's single write port. It merges in-order results from the pipeline WB stage with out-of-order results from long-latency units (loads, mul/div), buffering the latter in a small FIFO. It issues at most one registered write per cycle and publishes a pending-write mask that ID uses for hazard stalls. Writes to x0 are never issued.

## Interface
Parameters:
- DATA_WIDTH, 32, register data width
- REG_ADDR_WIDTH, 5, register address width
- NUM_REGS, 32, number of architectural registers
- FIFO_DEPTH, 4, long-latency result buffer entries (power of two, ≥2)
- STARVE_LIMIT, 8, cycles a FIFO head may lose arbitration before forced priority

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pipe_valid_i  in  1  in-order WB result present this cycle (always accepted)
- pipe_rd_addr_i  in  REG_ADDR_WIDTH  destination of pipeline result
- pipe_data_i  in  DATA_WIDTH  pipeline result
- lu_valid_i  in  1  long-latency result offered
- lu_ready_o  out  1  FIFO can accept; transfer when lu_valid_i && lu_ready_o
- lu_rd_addr_i  in  REG_ADDR_WIDTH  destination of long-latency result
- lu_data_i  in  DATA_WIDTH  long-latency result
- wr_addr_o  out  REG_ADDR_WIDTH  register-file write address (registered)
- wr_data_o  out  DATA_WIDTH  register-file write data (registered)
- WB_RegWrite_o  out  1  register-file write enable (registered)
- pending_mask_o  out  NUM_REGS  bit r set when any valid FIFO entry targets r
- wb_stall_o  out  1  registered; pipeline must present pipe_valid_i=0 this cycle
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- FIFO: circular buffer, head/tail pointers wrap at FIFO_DEPTH, count 0..FIFO_DEPTH; strict FIFO order.
- lu_ready_o = !rst && (count < FIFO_DEPTH); it does not depend on lu_valid_i or on a same-cycle pop (no push while full, even if popping).
- Accepted lu transfer with lu_rd_addr_i == 0: consumed (handshake completes) but not enqueued.
- Arbitration per cycle, priority order:
  1. wb_stall_o=1 and FIFO non-empty: pop head, issue it.
  2. pipe_valid_i=1 and pipe_rd_addr_i≠0: issue pipe result.
  3. FIFO non-empty: pop head, issue it.
  4. Otherwise: no write.
- pipe_valid_i with pipe_rd_addr_i=0: ignored; FIFO may drain that cycle (rule 3).
- Issue: next cycle WB_RegWrite_o=1 with the winner's addr/data; otherwise WB_RegWrite_o=0 and addr/data hold their previous values.
- Push and pop in the same cycle are allowed; count unchanged.
- Starvation: age counter increments each cycle the FIFO is non-empty and the head is not popped; clears on pop or when empty. When age reaches STARVE_LIMIT-1 and the head loses again, wb_stall_o=1 for exactly the next cycle. Rule 1 guarantees a pop in that cycle.
- pending_mask_o is combinational from valid entries; a popped entry's bit clears in the cycle after the pop. Upstream hazard logic guarantees pipe and FIFO never hold writes to the same register.

## Timing
- Reset (async assert): FIFO empty, pointers/count/age 0, WB_RegWrite_o=0, wr_addr_o=0, wr_data_o=0, wb_stall_o=0, pending_mask_o=0, lu_ready_o=0 while rst is high.
- Latency: pipe result → write enable 1 cycle. FIFO entry → write ≥1 cycle after enqueue (enqueued at edge N, earliest pop cycle N, write visible N+1).
- Throughput: one write per cycle; FIFO drains one entry per non-pipe cycle.
- Reset mid-operation discards all buffered entries; no partial write completes.

## Test plan
- Reset: assert rst mid-stream with 3 entries buffered → all outputs 0, lu_ready_o=0, count 0; after release, lu_ready_o=1 next cycle.
- Pipe only: pipe writes x5=0xDEADBEEF → next cycle WB_RegWrite_o=1, wr_addr_o=5, wr_data_o=0xDEADBEEF. pipe write to x0 → WB_RegWrite_o=0.
- FIFO order/full: push x1..x4 (data 0x11..0x44) with pipe busy → count=4, lu_ready_o=0, pending_mask_o=0x1E; drop pipe → writes x1,x2,x3,x4 on consecutive cycles, mask clears bit by bit.
- Simultaneous: count=2, push x7 while popping → count stays 2; lu write to x0 → handshake completes, count unchanged, no write.
- Starvation: one entry x9 plus continuous pipe writes → wb_stall_o pulses exactly STARVE_LIMIT cycles after enqueue, x9 written next cycle, then age clears.
- Back-to-back mix: alternating pipe and lu valid for 20 cycles → every accepted non-x0 result written exactly once, FIFO order preserved, no write lost.
